// File: rtl/xor_descr_pkg.sv
// Shared types, LFSR constants and the multi-step keystream helper for the
// nibble XOR descrambler (polynomial x^7+x^6+1).
package xor_descr_pkg;

   typedef enum logic {IDLE, RUN} state_e;

   localparam int            LFSR_W_DEF = 7;
   localparam int            TAP_HI     = LFSR_W_DEF - 1;
   localparam int            TAP_LO     = LFSR_W_DEF - 2;
   localparam logic [LFSR_W_DEF-1:0] SEED_DEF = 7'h7F;

   // Returns {state after n steps, key}; key is right-aligned so k0 lands in bit n-1.
   function automatic logic [2*LFSR_W_DEF-1:0] lfsr_step_n(input logic [LFSR_W_DEF-1:0] s,
                                                          input int n);
      logic [LFSR_W_DEF-1:0] st;
      logic [LFSR_W_DEF-1:0] key;
      logic                  f;
      st  = s;
      key = '0;
      for (int i = 0; i < LFSR_W_DEF; i++) begin
         if (i < n) begin
            f   = st[TAP_HI] ^ st[TAP_LO];
            st  = {st[LFSR_W_DEF-2:0], f};
            key = {key[LFSR_W_DEF-2:0], f};
         end
      end
      return {st, key};
   endfunction

endpackage

// File: rtl/xor_lfsr_ks.sv
// LFSR state register plus the DATA_W-step key generator; a zero seed is
// replaced by SEED so the register can never lock up.
module xor_lfsr_ks
   import xor_descr_pkg::*;
#(
   parameter int                 DATA_W = 4,
   parameter int                 LFSR_W = LFSR_W_DEF,
   parameter logic [LFSR_W-1:0]  SEED   = SEED_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic [LFSR_W-1:0] seed_i,
   input  logic              adv_i,
   output logic [DATA_W-1:0] key_o
);

   logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
   logic [2*LFSR_W-1:0] step;

   assign step  = lfsr_step_n(lfsr_q, DATA_W);
   assign key_o = step[DATA_W-1:0];

   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i)     lfsr_d = (seed_i == '0) ? SEED : seed_i;
      else if (adv_i) lfsr_d = step[2*LFSR_W-1:LFSR_W];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= SEED;
      else        lfsr_q <= lfsr_d;
   end

endmodule

// File: rtl/xor_descrambler.sv
// Nibble XOR descrambler: FSM, valid/ready handshake and registered output.
// Optional XOR_DESCR_BYPASS_EN adds a bypass port that passes data through unkeyed.
module xor_descrambler
   import xor_descr_pkg::*;
#(
   parameter int                 DATA_W = 4,
   parameter int                 LFSR_W = LFSR_W_DEF,
   parameter logic [LFSR_W-1:0]  SEED   = SEED_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed,
`ifdef XOR_DESCR_BYPASS_EN
   input  logic              bypass,
`endif
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy
);

   state_e            state_q, state_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [DATA_W-1:0] key, key_eff;
   logic              accept, adv;

   assign busy     = (state_q == RUN);
   assign in_ready = busy && !seed_load && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

`ifdef XOR_DESCR_BYPASS_EN
   assign key_eff = bypass ? '0 : key;
   assign adv     = accept && !bypass;
`else
   assign key_eff = key;
   assign adv     = accept;
`endif

   xor_lfsr_ks #(.DATA_W(DATA_W), .LFSR_W(LFSR_W), .SEED(SEED)) u_ks (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (seed_load),
      .seed_i (seed),
      .adv_i  (adv),
      .key_o  (key)
   );

   always_comb begin
      state_d = state_q;
      if (seed_load) state_d = RUN;
   end

   // A seed load discards whatever is pending; otherwise a new accept wins over a drain.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (seed_load) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data ^ key_eff;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule

// File: tb/tb_xor_descrambler.sv
// Scoreboard bench for xor_descrambler: directed keystream cases plus a
// randomized stream checked against a bit-recurrence keystream model.
module tb_xor_descrambler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       seed_load = 1'b0;
   logic [6:0] seed = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_data = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] out_data;
   logic       busy;

   int total = 0;
   int bad   = 0;
   logic [3:0] sb[$];
   bit   hist[$];
   bit   rnd_ready = 1'b0;

   xor_descrambler dut (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Keystream as a sequence x[t] = x[t-7] ^ x[t-6]; history starts as seed bits MSB first.
   task automatic model_seed(input logic [6:0] s);
      logic [6:0] v;
      v = (s == 0) ? 7'h7F : s;
      hist.delete();
      for (int i = 6; i >= 0; i--) hist.push_back(v[i]);
   endtask

   function automatic logic [3:0] model_key();
      logic [3:0] k;
      bit f;
      k = '0;
      for (int i = 0; i < 4; i++) begin
         f = hist[0] ^ hist[1];
         void'(hist.pop_front());
         hist.push_back(f);
         k = {k[2:0], f};
      end
      return k;
   endfunction

   // Monitor: an output transfer happens on the next edge when valid && ready now.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_output: got %0h expected none", out_data);
         end else begin
            logic [3:0] e;
            e = sb.pop_front();
            if (out_data !== e) begin
               bad++;
               $display("FAIL out_data: got %0h expected %0h", out_data, e);
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
   end

   // Drive one nibble; expected value comes from the model unless a literal is given.
   task automatic send(input logic [3:0] d, input bit use_lit, input logic [3:0] lit);
      bit done;
      logic [3:0] k;
      done = 0;
      in_valid = 1'b1;
      in_data  = d;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (in_ready) begin
            k = model_key();
            sb.push_back(use_lit ? lit : (d ^ k));
            done = 1;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      if (!done) check("accept_timeout", 0, 1);
   endtask

   task automatic load(input logic [6:0] s);
      seed_load = 1'b1;
      seed      = s;
      @(negedge clk);
      check("in_ready_during_load", in_ready, 0);
      if (out_valid && !out_ready && sb.size() > 0) void'(sb.pop_back());
      @(posedge clk); #1;
      seed_load = 1'b0;
      model_seed(s);
      check("out_valid_after_load", out_valid, 0);
      check("busy_after_load", busy, 1);
   endtask

   task automatic drain();
      for (int c = 0; c < 500 && sb.size() != 0; c++) @(posedge clk);
      #1;
      if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
   endtask

   initial begin
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // IDLE accepts nothing.
      in_valid = 1'b1; in_data = 4'h5; out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check("idle_in_ready", in_ready, 0);
         check("idle_out_valid", out_valid, 0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;

      // Known-answer streams for seed 7F and for a zero seed.
      for (int r = 0; r < 2; r++) begin
         load(r == 0 ? 7'h7F : 7'h00);
         send(4'b1000, 1, 4'b1000);
         send(4'b1000, 1, 4'b1010);
         send(4'b1000, 1, 4'b1000);
         send(4'b1000, 1, 4'b0100);
         drain();
      end

      // Back-pressure holds data and blocks input.
      load(7'h7F);
      out_ready = 1'b0;
      send(4'b1000, 1, 4'b1000);
      in_valid = 1'b1; in_data = 4'b1000;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("bp_out_valid", out_valid, 1);
         check("bp_out_data", out_data, 4'b1000);
         check("bp_in_ready", in_ready, 0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(4'b1000, 1, 4'b1010);
      drain();

      // Reload while an output is stalled: it is discarded and the stream restarts.
      out_ready = 1'b0;
      send(4'b0011, 0, 4'h0);
      load(7'h7F);
      out_ready = 1'b1;
      send(4'b1000, 1, 4'b1000);
      send(4'b1000, 1, 4'b1010);
      drain();

      // Randomized stream with random seeds, gaps and back-pressure.
      rnd_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         rnd_ready = 1'b0; out_ready = 1'b1;
         drain();
         load(7'($urandom));
         rnd_ready = 1'b1;
         for (int n = 0; n < 40; n++) begin
            send(4'($urandom), 0, 4'h0);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
         end
      end
      rnd_ready = 1'b0; out_ready = 1'b1;
      drain();

      // Asynchronous reset in the middle of a stream.
      load(7'h2A);
      out_ready = 1'b0;
      send(4'hC, 0, 4'h0);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_out_valid", out_valid, 0);
      check("async_busy", busy, 0);
      check("async_in_ready", in_ready, 0);
      sb.delete();
      @(posedge clk); #2;
      rst_n = 1'b1;
      out_ready = 1'b1; in_valid = 1'b1; in_data = 4'h3;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("post_rst_in_ready", in_ready, 0);
         check("post_rst_out_valid", out_valid, 0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      load(7'h7F);
      send(4'b1000, 1, 4'b1000);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
